pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Consumes the load-use hazard flag, the EXE-stage branch_taken and the MEM-stage SRAM handshake. Turns them into the per-stage freeze, flush and bubble controls for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
Owns the multi-cycle memory-wait state machine, a wait timeout with a sticky error, and saturating stall/flush performance counters.
Sits in the top-level core next to the hazard detection unit and drives the enables of the pipeline registers.

Parameters:
TIMEOUT_CYCLES, 64, max consecutive wait cycles before the error state is entered; legal range 2..2^WAIT_W-1
WAIT_W, 8, width of the wait-cycle counter
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
hazard  in  1  load-use hazard from the hazard detection unit (ID stage)
branch_taken  in  1  EXE-stage branch resolved taken
mem_req  in  1  MEM-stage SRAM access (read or write) this cycle
mem_ready  in  1  SRAM controller completes the access this cycle
clr_stats  in  1  synchronous clear of the performance counters
freeze_if  out  1  hold PC and the IF/ID register
bubble_id_exe  out  1  load a NOP (all control zero) into ID/EX
flush_if_id  out  1  zero the IF/ID register
freeze_all  out  1  hold every pipeline register and the PC
err  out  1  sticky memory-timeout error
state  out  2  current FSM state (RUN=0, WAIT=1, ERR=2)
stall_cnt  out  CNT_W  cycles in which freeze_all or freeze_if was asserted
flush_cnt  out  CNT_W  cycles in which flush_if_id was asserted

Behaviour:
- Reset (rst=0, async): state=RUN, wait_cnt=0, err=0, stall_cnt=0, flush_cnt=0. All control outputs are 0 while reset is held.
- Control outputs are combinational from state and inputs, so they act in the same cycle. Registers update on the rising clk edge.
- RUN priority, highest first:
  - mem_req&!mem_ready: freeze_all=1, all other controls 0. Next state=WAIT, wait_cnt=1.
  - branch_taken: flush_if_id=1 and bubble_id_exe=1; freeze_if=0. Hazard is ignored because the instruction is flushed.
  - hazard: freeze_if=1 and bubble_id_exe=1.
  - mem_req&mem_ready: zero-wait access with no effect; the lower priorities still apply.
- WAIT:
  - !mem_ready: freeze_all=1 and wait_cnt increments. If wait_cnt==TIMEOUT_CYCLES-1 in this cycle, next state=ERR.
  - mem_ready: freeze_all=0. The RUN rules for branch_taken and hazard apply in the same cycle. Next state=RUN, wait_cnt=0.
  - mem_req is not re-checked while in WAIT; the request is held by the frozen MEM stage.
- ERR: freeze_all=1, err=1, all other controls 0. The only exit is reset; mem_ready is ignored.
- Counters:
  - stall_cnt increments in any cycle with freeze_all|freeze_if.
  - flush_cnt increments in any cycle with flush_if_id.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - clr_stats has priority over increment: the counter reads 0 on the next cycle, even if an event occurs in the clear cycle.
- Reset mid-WAIT returns to RUN immediately. Nothing else about the pending access is retained.
- freeze_all and flush_if_id are never both 1 in the same cycle. A branch that arrives during a wait is held frozen and applied on the mem_ready cycle.

Decomposition:
- Shared package (core_pkg):
  - FSM state encoding constants ST_RUN, ST_WAIT, ST_ERR.
  - Default TIMEOUT_CYCLES.
- One sub-module, sat_counter, instantiated twice: parameter W; ports clk, rst, clr, inc, q.
- FSM and control decode stay in pipeline_stall_controller.

Test Plan:
- Reset, then hazard=1 for 1 cycle -> freeze_if=1, bubble_id_exe=1, flush_if_id=0, stall_cnt=1 afterwards.
- branch_taken=1 and hazard=1 together -> flush_if_id=1, bubble_id_exe=1, freeze_if=0, flush_cnt=1, stall_cnt=0.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> freeze_all=1 for exactly 3 cycles and state=WAIT during them; back to RUN after the ready cycle; stall_cnt=3.
- WAIT, then branch_taken=1 held until mem_ready -> no flush while frozen; flush_if_id=1 exactly on the mem_ready cycle.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> state=ERR after the 4th wait cycle; err=1 and freeze_all=1 persist even when mem_ready=1 later; rst=0 clears err asynchronously (before the next clk edge).
- CNT_W=4, hazard held 20 cycles -> stall_cnt saturates at 15; clr_stats=1 with hazard=1 -> stall_cnt=0 the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encoding and defaults.
package core_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Per-stage freeze/flush/bubble control for the 5-stage pipeline, with the
// memory-wait FSM, sticky timeout error and stall/flush performance counters.
module pipeline_stall_controller
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned WAIT_W         = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             freeze_if,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;
  logic              run_rules;

  // Controls act in the same cycle; everything is forced low while reset is held.
  always_comb begin
    freeze_if     = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    freeze_all    = 1'b0;
    run_rules     = 1'b0;
    if (rst) begin
      unique case (st)
        ST_ERR:  freeze_all = 1'b1;
        ST_WAIT: begin
          if (!mem_ready) freeze_all = 1'b1;
          else            run_rules  = 1'b1;
        end
        default: begin
          if (mem_req && !mem_ready) freeze_all = 1'b1;
          else                       run_rules  = 1'b1;
        end
      endcase
      if (run_rules) begin
        if (branch_taken) begin
          flush_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
        end else if (hazard) begin
          freeze_if     = 1'b1;
          bubble_id_exe = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= ST_RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      unique case (st)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            st       <= ST_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            st       <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            st  <= ST_ERR;
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ERR:  st <= ST_ERR;
        default: st <= ST_RUN;
      endcase
    end
  end

  assign state = st;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (freeze_all | freeze_if),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_stats),
    .inc (flush_if_id),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: a default instance and a small one
// (timeout 4, 4-bit counters) share stimulus and are checked against a rule model.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n, hazard, branch_taken, mem_req, mem_ready, clr_stats;

  logic        a_fi, a_bub, a_fl, a_fa, a_err;
  logic [1:0]  a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_fi, b_bub, b_fl, b_fa, b_err;
  logic [1:0]  b_st;
  logic [3:0]  b_sc, b_fc;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, index 0 = default instance, 1 = small instance.
  int m_st[2], m_w[2], m_sc[2], m_fc[2];
  int to_c[2] = '{64, 4};
  int cmax[2] = '{65535, 15};

  always #5 clk = ~clk;

  pipeline_stall_controller dut_a (
    .clk(clk), .rst(rst_n), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .freeze_if(a_fi), .bubble_id_exe(a_bub), .flush_if_id(a_fl),
    .freeze_all(a_fa), .err(a_err), .state(a_st),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipeline_stall_controller #(.TIMEOUT_CYCLES(4), .WAIT_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_n), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .freeze_if(b_fi), .bubble_id_exe(b_bub), .flush_if_id(b_fl),
    .freeze_all(b_fa), .err(b_err), .state(b_st),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_w[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  // Called at posedge+1: apply inputs, check at negedge, advance model at posedge.
  task automatic step(input bit r, input bit hz, input bit br, input bit rq,
                      input bit rd, input bit cl);
    bit ef[2], eb[2], efl[2], efa[2];
    rst_n = r; hazard = hz; branch_taken = br;
    mem_req = rq; mem_ready = rd; clr_stats = cl;
    if (!r) model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit ok_run;
      ef[i] = 0; eb[i] = 0; efl[i] = 0; efa[i] = 0; ok_run = 0;
      if (r) begin
        if (m_st[i] == 2)                    efa[i] = 1;
        else if (m_st[i] == 1 && !rd)        efa[i] = 1;
        else if (m_st[i] == 0 && rq && !rd)  efa[i] = 1;
        else                                 ok_run = 1;
        if (ok_run && br)      begin efl[i] = 1; eb[i] = 1; end
        else if (ok_run && hz) begin ef[i]  = 1; eb[i] = 1; end
      end
      if (i == 0) begin
        chk("a ctl", {a_fi, a_bub, a_fl, a_fa, a_err, a_st},
            {ef[0], eb[0], efl[0], efa[0], (m_st[0] == 2), 2'(m_st[0])});
        chk("a stall_cnt", 32'(a_sc), m_sc[0]);
        chk("a flush_cnt", 32'(a_fc), m_fc[0]);
      end else begin
        chk("b ctl", {b_fi, b_bub, b_fl, b_fa, b_err, b_st},
            {ef[1], eb[1], efl[1], efa[1], (m_st[1] == 2), 2'(m_st[1])});
        chk("b stall_cnt", 32'(b_sc), m_sc[1]);
        chk("b flush_cnt", 32'(b_fc), m_fc[1]);
      end
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        if (cl) m_sc[i] = 0;
        else if (efa[i] || ef[i]) m_sc[i] = (m_sc[i] + 1 > cmax[i]) ? cmax[i] : m_sc[i] + 1;
        if (cl) m_fc[i] = 0;
        else if (efl[i]) m_fc[i] = (m_fc[i] + 1 > cmax[i]) ? cmax[i] : m_fc[i] + 1;
        if (m_st[i] == 0 && rq && !rd) begin
          m_st[i] = 1; m_w[i] = 1;
        end else if (m_st[i] == 1) begin
          if (rd)                          begin m_st[i] = 0; m_w[i] = 0; end
          else if (m_w[i] == to_c[i] - 1)  m_st[i] = 2;
          else                             m_w[i]++;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hazard = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; clr_stats = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held with every request active: all controls stay low.
    step(0, 1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Load-use hazard for one cycle.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("hazard stall_cnt", 32'(a_sc), 1);

    // Branch overrides hazard.
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("branch flush_cnt", 32'(a_fc), 1);

    // Three-cycle memory wait, then ready.
    repeat (3) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("wait stall_cnt", 32'(a_sc), 4);

    // Branch arriving during a wait is deferred to the ready cycle.
    step(1, 0, 0, 1, 0, 0);
    repeat (2) step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);

    // Timeout: the small instance enters ERR and ignores mem_ready afterwards.
    repeat (6) step(1, 0, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("err sticky", 32'(b_err), 1);

    // Asynchronous reset clears ERR before the next clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async err", 32'(b_err), 0);
    chk("async state", 32'(b_st), 0);
    chk("async freeze_all", 32'(b_fa), 0);
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Counter saturation on the 4-bit instance, then clear beats increment.
    repeat (20) step(1, 1, 0, 0, 0, 0);
    chk("sat stall_cnt", 32'(b_sc), 15);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("clr stall_cnt", 32'(b_sc), 0);

    // Randomized traffic with occasional resets.
    repeat (400)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
